// File: rtl/load_store_unit.sv
// Load/store unit for an RV32I core: sub-word load extraction and extension,
// single-cycle word stores, and a two-cycle read-modify-write for byte and
// halfword stores against a word-wide, combinationally read data memory.
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic [31:0] A_mem,
    output logic [31:0] DataIP,
    output logic        MemWE,
    input  logic [31:0] D_read
);

    localparam int unsigned WORD_W = 32;
    localparam logic [2:0]  F3_B   = 3'b000;
    localparam logic [2:0]  F3_H   = 3'b001;
    localparam logic [2:0]  F3_W   = 3'b010;
    localparam logic [2:0]  F3_BU  = 3'b100;
    localparam logic [2:0]  F3_HU  = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   word_q;

    logic                misaligned;
    logic                illegal;
    logic                out_of_range;
    logic                req_err;
    logic                sub_store;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [WORD_W-1:0]   ld_ext;
    logic [WORD_W-1:0]   merged;

    // Memory word index; the top two bits are structurally zero.
    assign A_mem = {2'b00, addr[31:2]};

    // Request legality: alignment, funct3 encoding and address range.
    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = addr[0];
            F3_W:        misaligned = |addr[1:0];
            default:     misaligned = 1'b0;
        endcase
        illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (req_we && funct3[2]);
        out_of_range = WORD_W'(addr[31:2]) >= WORD_W'(DEPTH_WORDS);
        req_err      = misaligned || illegal || out_of_range;
        sub_store    = req_we && (funct3[1:0] != 2'b10);
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        case (addr[1:0])
            2'd0:    ld_byte = D_read[7:0];
            2'd1:    ld_byte = D_read[15:8];
            2'd2:    ld_byte = D_read[23:16];
            default: ld_byte = D_read[31:24];
        endcase
        ld_half = addr[1] ? D_read[31:16] : D_read[15:0];
        case (funct3)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_ext = {24'h0, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_ext = {16'h0, ld_half};
            default: ld_ext = D_read;
        endcase
    end

    // Store merge: replace the target lane of the captured word.
    always_comb begin
        merged = word_q;
        if (funct3[0]) begin
            if (addr[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
        end else begin
            case (addr[1:0])
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end
    end

    // State register and RMW capture of the old memory word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            word_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == WRITE) begin
                word_q <= D_read;
            end
        end
    end

    // Next state: only a legal sub-word store leaves IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid && !req_err && sub_store) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and memory-control outputs; reset forces them quiet.
    always_comb begin
        rdata  = '0;
        done   = 1'b0;
        stall  = 1'b0;
        err    = 1'b0;
        MemWE  = 1'b0;
        DataIP = wdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else if (!req_we) begin
                        done  = 1'b1;
                        rdata = ld_ext;
                    end else if (!sub_store) begin
                        done  = 1'b1;
                        MemWE = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            WRITE: begin
                MemWE  = 1'b1;
                DataIP = merged;
                done   = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            rdata = '0;
            done  = 1'b0;
            stall = 1'b0;
            err   = 1'b0;
            MemWE = 1'b0;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the attached data memory (must be a power of two).
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: req_valid  input  1  memory request present this cycle.
REQ-005: req_we  input  1  1 = store, 0 = load.
REQ-006: funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007: addr  input  32  byte address.
REQ-008: wdata  input  32  store data; the low byte or halfword is used for sub-word stores.
REQ-009: rdata  output  32  extended load result.
REQ-010: done  output  1  request completes this cycle.
REQ-011: stall  output  1  request is not complete; the core holds all request inputs stable.
REQ-012: err  output  1  misaligned, illegal-funct3 or out-of-range request; pulses with done.
REQ-013: A_mem  output  32  word index to memory, {2'b00, addr[31:2]}.
REQ-014: DataIP  output  32  word written to memory.
REQ-015: MemWE  output  1  memory write enable, active high; memory writes at the rising clk edge.
REQ-016: D_read  input  32  memory read word, combinational from A_mem while MemWE=0.

Function
REQ-017: The FSM SHALL have two states: IDLE and WRITE; word_q (32 bits) SHALL hold the captured memory word.
REQ-018: Error checks, in IDLE with req_valid=1:
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0;
  - illegal funct3: 011/110/111, or a store with funct3[2]=1;
  - out of range: addr[31:2] >= DEPTH_WORDS.
  Any of these SHALL give done=1, err=1, MemWE=0 that same cycle, with state unchanged.
REQ-019: A valid load SHALL complete combinationally in IDLE: MemWE=0, done=1, stall=0, rdata extended from D_read.
REQ-020: Load lane select and extension:
  - B/BU use byte addr[1:0]; H/HU use halfword addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the full word.
REQ-021: A valid SW SHALL complete in IDLE: MemWE=1, DataIP=wdata, done=1, stall=0.
REQ-022: A valid SB or SH SHALL run a read-modify-write:
  - Cycle 0 (IDLE): MemWE=0, stall=1, done=0; D_read is captured into word_q; next state WRITE.
  - Cycle 1 (WRITE): MemWE=1, DataIP = word_q with the target lane replaced by wdata[7:0] or wdata[15:0]; done=1, stall=0; next state IDLE.
REQ-023: In WRITE, A_mem SHALL still be driven from addr; request inputs are assumed stable; req_valid is ignored.
REQ-024: With req_valid=0 in IDLE: MemWE=0, done=0, stall=0, err=0, and rdata=0.
REQ-025: Back-to-back requests SHALL be accepted in the cycle immediately after done, with no bubble.
REQ-026: A_mem bits [31:30] SHALL always be 0; no address wrap is performed, since out-of-range addresses are rejected by REQ-018.
REQ-027: MemWE SHALL never be 1 in a cycle where err=1 or rst_n=0.

Reset
REQ-028: When rst_n=0: state=IDLE, word_q=0, MemWE=0, done=0, stall=0, err=0, rdata=0, forced asynchronously.
REQ-029: Reset asserted during WRITE SHALL abort the RMW with no memory write; after release, the block is in IDLE.
REQ-030: On rst_n deassertion, the first request SHALL be accepted at the next rising edge.

Verification
REQ-031: Memory word 0x10 = 0x8899AABB; LB at addr 0x41 -> same cycle rdata=0xFFFFFFAA, done=1; LBU at 0x41 -> 0x000000AA.
REQ-032: SW 0xDEADBEEF at addr 0x8 -> one cycle, MemWE=1, A_mem=0x2; a following LW at 0x8 -> 0xDEADBEEF.
REQ-033: Word 0x3 = 0x11223344; SH wdata=0x0000CAFE at addr 0xE -> cycle 0: stall=1, MemWE=0; cycle 1: MemWE=1, DataIP=0xCAFE3344; next cycle an SB is accepted.
REQ-034: LW at addr 0x6 -> err=1, done=1, MemWE=0; SW at 0x1000 with DEPTH_WORDS=1024 -> err=1, no write.
REQ-035: SB started, rst_n pulled low during WRITE -> MemWE=0 immediately; memory word unchanged; state IDLE after release.
